// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl - single-level interrupt controller
//
// This block sits behind the control unit's iack/rfe handshake. It latches
// rising edges on the peripheral interrupt lines into a pending register. It
// picks the lowest-index enabled pending line and raises one request,
// together with that line's handler vector. It then tracks the interrupt
// from acknowledge until return-from-exception. Interrupts do not nest.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset (overrides every other input)
//   irq         peripheral interrupt lines, rising-edge triggered
//   irq_mask    1 = line may be granted; masked lines still latch pending
//   iack        one-cycle acknowledge strobe, honoured only while requesting
//   rfe         [0] return from handler, [1] flush all pending bits
//   int_req     interrupt request to the CPU
//   int_id      id of the granted or in-service line
//   int_vec     VEC_BASE + int_id * VEC_STRIDE
//   in_service  a handler is running
//   pending     latched pending bits
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int          N_IRQ      = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             iack,
  input  logic [1:0]       rfe,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic [31:0]      int_vec,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             int_req_q, int_req_d;
  logic             in_service_q, in_service_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_prev_q;

  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] pend_clr;
  logic [N_IRQ-1:0] candidates;
  logic             any_cand;
  logic [ID_W-1:0]  winner;
  logic             ack_now;
  logic             flush;

  assign flush   = rfe[1];
  assign ack_now = (state_q == ST_REQ) && iack;

  // Edge detect, then per-bit pending update. A new edge always wins over a
  // clear in the same cycle, so an interrupt arriving exactly while its
  // previous instance is being acknowledged or flushed is not lost.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign irq_edge[gi]  = irq[gi] & ~irq_prev_q[gi];
      assign pend_clr[gi]  = flush | (ack_now && (int_id_q == ID_W'(gi)));
      assign pending_d[gi] = (pending_q[gi] & ~pend_clr[gi]) | irq_edge[gi];
    end
  endgenerate

  // A flush in the same cycle removes every candidate. That way the
  // controller never grants a line whose pending bit is being wiped.
  assign candidates = pending_q & irq_mask & {N_IRQ{~flush}};
  assign any_cand   = |candidates;

  // Lowest index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    int_id_d     = int_id_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_cand) begin
          state_d   = ST_REQ;
          int_id_d  = winner;
          int_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        // The acknowledge has already been accepted by the control unit, so
        // it outranks both the mask withdraw and a flush.
        if (iack) begin
          state_d      = ST_SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end else if (flush || !irq_mask[int_id_q]) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        // int_id keeps its value after return until the next grant.
        if (rfe[0]) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      int_id_q     <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      // Cleared so that a line already high when reset releases counts as
      // an edge.
      irq_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      int_id_q     <= int_id_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      irq_prev_q   <= irq;
    end
  end

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign int_vec    = VEC_BASE + (32'(int_id_q) * VEC_STRIDE);

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller at the far end of the control unit's `iack`/`rfe` interface.
- Latches rising edges on peripheral interrupt lines and prioritises them.
- Presents one request plus a handler vector to the CPU datapath.
- Tracks the in-service interrupt from acknowledge (`iack`) until return (`rfe`); single level, no nesting.

Parameters:
- N_IRQ, 4, number of interrupt lines (1..2**ID_W).
- ID_W, 2, width of interrupt id.
- VEC_BASE, 32'h0000_0100, vector address of id 0.
- VEC_STRIDE, 32'd16, byte spacing between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  N_IRQ  peripheral interrupt lines, rising-edge triggered, synchronous to clk.
- irq_mask  in  N_IRQ  1 = line enabled; masked lines still latch pending.
- iack  in  1  interrupt acknowledge from control unit, one-cycle strobe.
- rfe  in  2  from control unit: 00 none, 01 return, 10 flush pending, 11 return + flush.
- int_req  out  1  interrupt request to CPU.
- int_id  out  ID_W  id of granted or in-service line.
- int_vec  out  32  VEC_BASE + int_id*VEC_STRIDE.
- in_service  out  1  handler running.
- pending  out  N_IRQ  latched pending bits.

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs):
  - state=IDLE; int_req=0, int_id=0, int_vec=VEC_BASE, in_service=0, pending=0.
  - irq_prev=0, so a line already high when rst releases counts as an edge.
- Edge detect and pending:
  - irq_prev registers irq every cycle.
  - A bit sets when irq & ~irq_prev is seen at an edge.
  - A set and a clear of the same bit in the same cycle: set wins, so no edge is lost.
- Priority: lowest index among pending & irq_mask wins.
- int_vec: combinational from int_id; 32-bit arithmetic, wrap-around ignored.
- State IDLE:
  - If any pending & irq_mask bit is set: at the next edge go to REQ, latch int_id = winner, int_req=1.
  - Otherwise stay in IDLE.
- State REQ (int_req=1; int_id held even if a higher-priority line arrives):
  - iack=1: at the edge go to SERVICE. int_req=0, in_service=1, pending[int_id] cleared unless a new edge arrives on that line the same cycle.
  - iack=0 and irq_mask[int_id]=0: withdraw to IDLE. int_req=0, pending kept.
  - iack takes precedence over the mask withdraw in the same cycle.
- State SERVICE (int_req=0, in_service=1):
  - New edges still latch into pending.
  - rfe[0]=1: go to IDLE, in_service=0. int_id holds its value until the next grant.
  - If another line is pending and enabled, REQ follows one cycle later.
- rfe[1]=1 in any state:
  - Clears all pending bits, except bits receiving a new edge that same cycle.
  - In REQ, this also forces return to IDLE with int_req=0.
- Ignored inputs: iack outside REQ; rfe[0] outside SERVICE.
- Latency:
  - Edge sampled at clock k → pending visible after k.
  - int_req visible after k+1.
  - iack at edge m → in_service after m.
- Reset mid-operation, in any state: all state returns to reset values at that edge; in-service and pending are lost.

Test Plan:
- Reset, irq=0000, mask=1111; pulse irq[2] one cycle → pending=0100 after 1 clk; int_req=1, int_id=2, int_vec=0x120 after 2 clks.
- irq[3] and irq[1] rise same cycle → int_id=1, vec=0x110. iack → in_service=1, pending=1000. rfe=01 → IDLE; next cycle int_req=1, int_id=3, vec=0x130.
- In SERVICE of id 0, pulse irq[0] again → pending[0]=1, int_req stays 0. After rfe=01 → re-request of id 0.
- In REQ for id 2, drop mask[2] with no iack → int_req=0 next cycle, pending[2]=1 retained. Restore mask → int_req=1 again.
- Simultaneous: iack in REQ for id 1 while irq[1] rises → SERVICE entered, pending[1] stays 1. Separately, rfe=10 with pending=1010 → pending=0000.
- Assert rst while in SERVICE with pending=0110 → all outputs 0, int_vec=0x100. iack and rfe pulses afterwards produce no change.
